// File: rtl/risc16b_mem_arbiter.sv
// risc16b_mem_arbiter
// Shares one single-port, word-wide external SRAM between the risc16b
// instruction port (read-only) and data port, and decodes an internal I/O
// page holding the LED register and a free-running cycle counter.
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   i_req/i_addr          instruction fetch request and byte address
//   i_rdata/i_ack         fetched word and one-cycle completion pulse
//   d_req/d_addr/d_we     data request, byte address, byte-lane write enables
//   d_wdata               data write word
//   d_rdata/d_ack         data read word and one-cycle completion pulse
//   mem_addr/mem_oe       SRAM word address and read enable
//   mem_we/mem_wdata      SRAM byte-lane write enables and write data
//   mem_rdata             SRAM read data (combinational while mem_oe=1)
//   led                   LED register
module risc16b_mem_arbiter #(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] IO_PAGE     = 8'h7f
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic [15:0] mem_addr,
    output logic        mem_oe,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] led
);

    localparam int             WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_IO   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic           r_lastGrantD;
    logic           r_grantD;
    logic [15:1]    r_addr;
    logic [1:0]     r_we;
    logic [15:0]    r_wdata;
    logic [WCW-1:0] r_waitCnt;
    logic [15:0]    r_cycleCnt;
    logic [15:0]    r_led;
    logic [15:0]    r_iRdata;
    logic [15:0]    r_dRdata;

    logic           w_grantD;
    logic [15:1]    w_selAddr;
    logic           w_isRead;
    logic           w_memLast;
    logic           w_capture;
    logic [15:0]    w_ioRdata;
    logic [15:0]    w_readData;
    logic           w_unusedBits;

    // Byte address bit 0 is ignored on both ports.
    assign w_unusedBits = i_addr[0] ^ d_addr[0];

    // Round-robin: a lone requester wins; when both request, the port that
    // did not win last time wins. last_grant resets to I, so D wins first.
    assign w_grantD  = d_req & (~i_req | ~r_lastGrantD);
    assign w_selAddr = w_grantD ? d_addr[15:1] : i_addr[15:1];

    assign w_isRead  = (r_we == 2'b00);
    assign w_memLast = (r_waitCnt == WAIT_LAST);
    assign w_capture = w_isRead &
                       (((r_state == S_MEM) & w_memLast) | (r_state == S_IO));

    always_comb begin
        w_ioRdata = 16'h0000;
        case (r_addr[7:1])
            7'd0:    w_ioRdata = r_led;
            7'd1:    w_ioRdata = r_cycleCnt;
            default: w_ioRdata = 16'h0000;
        endcase
    end

    assign w_readData = (r_state == S_IO) ? w_ioRdata : mem_rdata;

    // Memory strobes are decoded from the state registers, so an async reset
    // removes them immediately. The write strobe is confined to the final
    // MEM cycle so the SRAM sees exactly one write edge.
    assign mem_addr  = (r_state == S_MEM) ? {r_addr, 1'b0} : 16'h0000;
    assign mem_oe    = (r_state == S_MEM) & w_isRead;
    assign mem_we    = ((r_state == S_MEM) & w_memLast) ? r_we : 2'b00;
    assign mem_wdata = r_wdata;

    assign i_ack   = (r_state == S_DONE) & ~r_grantD;
    assign d_ack   = (r_state == S_DONE) &  r_grantD;
    assign i_rdata = r_iRdata;
    assign d_rdata = r_dRdata;
    assign led     = r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycleCnt <= 16'h0000;
        end else begin
            r_cycleCnt <= r_cycleCnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lastGrantD <= 1'b0;
            r_grantD     <= 1'b0;
            r_addr       <= '0;
            r_we         <= 2'b00;
            r_wdata      <= 16'h0000;
            r_waitCnt    <= '0;
            r_led        <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req | d_req) begin
                        r_grantD     <= w_grantD;
                        r_lastGrantD <= w_grantD;
                        r_addr       <= w_selAddr;
                        // The instruction port can never write.
                        r_we         <= w_grantD ? d_we : 2'b00;
                        r_wdata      <= w_grantD ? d_wdata : 16'h0000;
                        r_waitCnt    <= '0;
                        r_state      <= (w_selAddr[15:8] == IO_PAGE) ? S_IO : S_MEM;
                    end
                end
                S_MEM: begin
                    if (w_memLast) begin
                        r_waitCnt <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + WCW'(1);
                    end
                end
                S_IO: begin
                    // Only the LED register is writable; everything else in
                    // the page silently drops writes.
                    if (!w_isRead && (r_addr[7:1] == 7'd0)) begin
                        if (r_we[0]) r_led[15:8] <= r_wdata[15:8];
                        if (r_we[1]) r_led[7:0]  <= r_wdata[7:0];
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data is held per port until that port's next completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iRdata <= 16'h0000;
            r_dRdata <= 16'h0000;
        end else if (w_capture) begin
            if (r_grantD) r_dRdata <= w_readData;
            else          r_iRdata <= w_readData;
        end
    end

endmodule

// File: tb/tb_risc16b_mem_arbiter.sv
// tb_risc16b_mem_arbiter
// Directed testbench for risc16b_mem_arbiter with a small SRAM model.
module tb_risc16b_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic [15:0] d_addr;
    logic [1:0]  d_we;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic [15:0] mem_addr;
    logic        mem_oe;
    logic [1:0]  mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] led;

    int errors;
    int checks;
    int tbEdges;

    logic [15:0] memArr [0:255];
    logic        loadEn;
    logic [7:0]  loadIdx;
    logic [15:0] loadData;

    risc16b_mem_arbiter #(.WAIT_CYCLES(2), .IO_PAGE(8'h7f)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: combinational read, byte-lane write on the rising edge.
    assign mem_rdata = mem_oe ? memArr[mem_addr[8:1]] : 16'hdead;

    always @(posedge clk) begin
        if (loadEn) memArr[loadIdx] <= loadData;
        if (mem_we[0]) memArr[mem_addr[8:1]][15:8] <= mem_wdata[15:8];
        if (mem_we[1]) memArr[mem_addr[8:1]][7:0]  <= mem_wdata[7:0];
    end

    // Reference cycle count: edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbEdges <= 0;
        else        tbEdges <= tbEdges + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic preloadWord(input logic [7:0] idx, input logic [15:0] data);
        loadEn   = 1'b1;
        loadIdx  = idx;
        loadData = data;
        @(posedge clk);
        #1 loadEn = 1'b0;
    endtask

    // Issues one request during an IDLE cycle and watches until the ack.
    task automatic applyStimulus(input bit isD, input logic [15:0] addr,
                                 input logic [1:0] we, input logic [15:0] wdata,
                                 output int lat, output int oeN, output int weN,
                                 output logic [1:0] weSeen, output logic [15:0] rd,
                                 output bit got, output logic [15:0] addrSeen);
        lat = 0; oeN = 0; weN = 0; weSeen = 2'b00; rd = 16'h0; got = 1'b0;
        addrSeen = 16'h0;
        @(negedge clk);
        if (isD) begin
            d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (mem_oe) begin
                oeN++;
                addrSeen = mem_addr;
            end
            if (mem_we != 2'b00) begin
                weN++;
                weSeen   = mem_we;
                addrSeen = mem_addr;
            end
            if (isD ? d_ack : i_ack) begin
                got = 1'b1;
                lat = c;
                rd  = isD ? d_rdata : i_rdata;
            end
        end
        if (isD) begin
            d_req = 1'b0; d_we = 2'b00;
        end else begin
            i_req = 1'b0;
        end
    endtask

    int          lat, oeN, weN, nAck, wraps;
    logic [1:0]  weSeen;
    logic [15:0] rd, addrSeen, prevVal, expVal;
    bit          got, found;

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; loadEn = 1'b0; loadIdx = 8'h0; loadData = 16'h0;
        i_req = 1'b0; i_addr = 16'h0;
        d_req = 1'b0; d_addr = 16'h0; d_we = 2'b00; d_wdata = 16'h0;

        preloadWord(8'd8,  16'h1234);
        preloadWord(8'd16, 16'h5555);
        preloadWord(8'd32, 16'hBEEF);
        preloadWord(8'd48, 16'h0000);
        @(negedge clk);

        checkOutput("rstIAck",     i_ack,     1'b0);
        checkOutput("rstDAck",     d_ack,     1'b0);
        checkOutput("rstIRdata",   i_rdata,   16'h0);
        checkOutput("rstDRdata",   d_rdata,   16'h0);
        checkOutput("rstMemOe",    mem_oe,    1'b0);
        checkOutput("rstMemWe",    mem_we,    2'b00);
        checkOutput("rstMemAddr",  mem_addr,  16'h0);
        checkOutput("rstMemWdata", mem_wdata, 16'h0);
        checkOutput("rstLed",      led,       16'h0);
        rst_n = 1'b1;

        // Single instruction read, odd byte address.
        applyStimulus(1'b0, 16'h0011, 2'b00, 16'h0, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("rdAck",   got,      1'b1);
        checkOutput("rdLat",   lat,      3);
        checkOutput("rdOeN",   oeN,      2);
        checkOutput("rdWeN",   weN,      0);
        checkOutput("rdAddr",  addrSeen, 16'h0010);
        checkOutput("rdData",  rd,       16'h1234);
        @(negedge clk);
        checkOutput("rdAckPulse", i_ack,   1'b0);
        checkOutput("rdHold",     i_rdata, 16'h1234);

        // Byte write to the high lane.
        applyStimulus(1'b1, 16'h0020, 2'b01, 16'hABCD, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("bwAck",  got,         1'b1);
        checkOutput("bwLat",  lat,         3);
        checkOutput("bwWeN",  weN,         1);
        checkOutput("bwWe",   weSeen,      2'b01);
        checkOutput("bwOeN",  oeN,         0);
        checkOutput("bwMem",  memArr[16],  16'hAB55);
        applyStimulus(1'b1, 16'h0020, 2'b00, 16'h0, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("bwReadBack", rd, 16'hAB55);
        applyStimulus(1'b1, 16'h0050, 2'b11, 16'h7777, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("wrKeepsRdata", d_rdata,    16'hAB55);
        checkOutput("wrFullWord",   memArr[40], 16'h7777);

        // LED register in the I/O page.
        applyStimulus(1'b1, 16'h7f00, 2'b11, 16'h00F0, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("ledLat", lat, 2);
        checkOutput("ledOeN", oeN, 0);
        checkOutput("ledWeN", weN, 0);
        checkOutput("ledVal", led, 16'h00F0);
        applyStimulus(1'b1, 16'h7f00, 2'b00, 16'h0, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("ledRead", rd, 16'h00F0);
        applyStimulus(1'b1, 16'h7f10, 2'b11, 16'hFFFF, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("ioDropWr", led, 16'h00F0);
        applyStimulus(1'b1, 16'h7f10, 2'b00, 16'h0, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("ioUnmapped", rd, 16'h0000);
        applyStimulus(1'b1, 16'h7f00, 2'b10, 16'h1234, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("ledLowLane", led, 16'h0034);
        applyStimulus(1'b0, 16'h7f01, 2'b00, 16'h0, lat, oeN, weN, weSeen, rd, got, addrSeen);
        checkOutput("ledIPortLat",  lat, 2);
        checkOutput("ledIPortRead", rd,  16'h0034);

        // Contention: both ports held from reset release.
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkOutput("rstLedClr", led, 16'h0);
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_addr = 16'h0040; d_we = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        nAck = 0;
        for (int c = 0; c < 40 && nAck < 4; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                checkOutput("contOrder", {d_ack, i_ack}, (nAck % 2 == 0) ? 2'b10 : 2'b01);
                if (nAck % 2 == 0) checkOutput("contDData", d_rdata, 16'hBEEF);
                else               checkOutput("contIData", i_rdata, 16'h1234);
                nAck++;
                if (nAck == 4) begin
                    i_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        checkOutput("contAckCount", nAck, 4);

        // Reset in the write cycle of a memory write.
        @(negedge clk);
        d_req = 1'b1; d_addr = 16'h0060; d_we = 2'b11; d_wdata = 16'hCAFE;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (mem_we != 2'b00) found = 1'b1;
        end
        checkOutput("rmwFoundWe", found, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rmwWeDrop",  mem_we, 2'b00);
        checkOutput("rmwNoAck",   d_ack,  1'b0);
        @(negedge clk);
        checkOutput("rmwNoAck2",  d_ack,      1'b0);
        checkOutput("rmwMemKept", memArr[48], 16'h0000);
        checkOutput("rmwOeIdle",  mem_oe,     1'b0);
        rst_n = 1'b1;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1; lat = c;
                d_req = 1'b0; d_we = 2'b00;
            end
        end
        d_req = 1'b0; d_we = 2'b00;
        checkOutput("rmwReserved", got,        1'b1);
        checkOutput("rmwLat",      lat,        3);
        checkOutput("rmwMemNew",   memArr[48], 16'hCAFE);

        // Cycle counter wrap: run up close to 16'hffff and read repeatedly.
        while (tbEdges < 65520) @(negedge clk);
        wraps = 0; prevVal = 16'h0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 16'h7f02, 2'b00, 16'h0, lat, oeN, weN, weSeen, rd, got, addrSeen);
            expVal = 16'(tbEdges - 1);
            checkOutput("cntRead", rd, expVal);
            if (k > 0 && rd < prevVal) wraps++;
            prevVal = rd;
        end
        checkOutput("cntWrapSeen", wraps, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
